// File: rtl/fp_to_int_conv.sv
// Iterative IEEE-754 float to signed integer converter (truncate toward zero).
// The mantissa is shifted one bit per cycle; the result is presented on a valid/ready port.
module fp_to_int_conv #(
   parameter int N_BIT   = 64,
   parameter int EXP_BIT = 11,
   parameter int INT_BIT = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N_BIT-1:0]   a,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INT_BIT-1:0] out,
   output logic               invalid,
   output logic               inexact
);

   localparam int FRAC = N_BIT - 1 - EXP_BIT;
   localparam int BIAS = 2**(EXP_BIT-1) - 1;
   localparam int EW   = EXP_BIT + 2;
   localparam logic [INT_BIT-1:0] MAXV = {1'b0, {(INT_BIT-1){1'b1}}};
   localparam logic [INT_BIT-1:0] MINV = {1'b1, {(INT_BIT-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CLASSIFY, SHIFT, DONE} state_t;

   state_t             r_state, w_stateNext;
   logic [N_BIT-1:0]   r_a, w_aNext;
   logic [INT_BIT-1:0] r_mag, w_magNext;
   logic [EW-1:0]      r_cnt, w_cntNext;
   logic               r_left, w_leftNext;
   logic               r_sticky, w_stickyNext;
   logic [INT_BIT-1:0] r_out, w_outNext;
   logic               r_invalid, w_invalidNext;
   logic               r_inexact, w_inexactNext;
   logic               r_outValid, w_outValidNext;
   logic               r_inReady, w_inReadyNext;

   logic                  w_sign;
   logic [EXP_BIT-1:0]    w_exp;
   logic [FRAC-1:0]       w_frac;
   logic signed [EW-1:0]  w_e;
   logic                  w_expOnes, w_expZero, w_fracNz, w_leftDir;
   logic [INT_BIT-1:0]    w_mant;
   logic [EW-1:0]         w_shiftAmt;
   logic [INT_BIT-1:0]    w_magShift;
   logic                  w_stickyShift;

   assign w_sign    = r_a[N_BIT-1];
   assign w_exp     = r_a[N_BIT-2:FRAC];
   assign w_frac    = r_a[FRAC-1:0];
   assign w_e       = $signed({2'b00, w_exp}) - $signed(EW'(BIAS));
   assign w_expOnes = &w_exp;
   assign w_expZero = ~|w_exp;
   assign w_fracNz  = |w_frac;
   assign w_mant    = {{(INT_BIT-FRAC-1){1'b0}}, 1'b1, w_frac};
   assign w_leftDir = w_e > $signed(EW'(FRAC));
   assign w_shiftAmt = w_leftDir ? EW'(w_e - $signed(EW'(FRAC)))
                                 : EW'($signed(EW'(FRAC)) - w_e);

   // Bits falling off the bottom of a right shift are what truncation discards.
   assign w_magShift    = r_left ? (r_mag << 1) : (r_mag >> 1);
   assign w_stickyShift = r_sticky | (~r_left & r_mag[0]);

   always_comb begin
      w_stateNext    = r_state;
      w_aNext        = r_a;
      w_magNext      = r_mag;
      w_cntNext      = r_cnt;
      w_leftNext     = r_left;
      w_stickyNext   = r_sticky;
      w_outNext      = r_out;
      w_invalidNext  = r_invalid;
      w_inexactNext  = r_inexact;
      w_outValidNext = r_outValid;
      w_inReadyNext  = r_inReady;
      case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_aNext       = a;
               w_invalidNext = 1'b0;
               w_inexactNext = 1'b0;
               w_inReadyNext = 1'b0;
               w_stateNext   = CLASSIFY;
            end
         end
         CLASSIFY: begin
            w_stickyNext   = 1'b0;
            w_stateNext    = DONE;
            w_outValidNext = 1'b1;
            if (w_expOnes && w_fracNz) begin
               w_outNext     = '0;
               w_invalidNext = 1'b1;
            end else if (w_expOnes) begin
               w_outNext     = w_sign ? MINV : MAXV;
               w_invalidNext = 1'b1;
            end else if (w_expZero) begin
               w_outNext     = '0;
               w_inexactNext = w_fracNz;
            end else if (w_e < 0) begin
               w_outNext     = '0;
               w_inexactNext = 1'b1;
            end else if (w_e >= $signed(EW'(INT_BIT-1))) begin
               // Only -2**(INT_BIT-1) itself is representable at this magnitude.
               if (w_sign && (w_e == $signed(EW'(INT_BIT-1))) && !w_fracNz) begin
                  w_outNext = MINV;
               end else begin
                  w_outNext     = w_sign ? MINV : MAXV;
                  w_invalidNext = 1'b1;
               end
            end else begin
               w_magNext  = w_mant;
               w_leftNext = w_leftDir;
               w_cntNext  = w_shiftAmt;
               if (w_shiftAmt == '0) begin
                  w_outNext = w_sign ? -w_mant : w_mant;
               end else begin
                  w_stateNext    = SHIFT;
                  w_outValidNext = 1'b0;
               end
            end
         end
         SHIFT: begin
            w_magNext    = w_magShift;
            w_stickyNext = w_stickyShift;
            w_cntNext    = r_cnt - EW'(1);
            if (r_cnt == EW'(1)) begin
               w_outNext      = w_sign ? -w_magShift : w_magShift;
               w_inexactNext  = w_stickyShift;
               w_outValidNext = 1'b1;
               w_stateNext    = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               w_outValidNext = 1'b0;
               w_inReadyNext  = 1'b1;
               w_stateNext    = IDLE;
            end
         end
         default: w_stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_a        <= '0;
         r_mag      <= '0;
         r_cnt      <= '0;
         r_left     <= 1'b0;
         r_sticky   <= 1'b0;
         r_out      <= '0;
         r_invalid  <= 1'b0;
         r_inexact  <= 1'b0;
         r_outValid <= 1'b0;
         r_inReady  <= 1'b1;
      end else begin
         r_state    <= w_stateNext;
         r_a        <= w_aNext;
         r_mag      <= w_magNext;
         r_cnt      <= w_cntNext;
         r_left     <= w_leftNext;
         r_sticky   <= w_stickyNext;
         r_out      <= w_outNext;
         r_invalid  <= w_invalidNext;
         r_inexact  <= w_inexactNext;
         r_outValid <= w_outValidNext;
         r_inReady  <= w_inReadyNext;
      end
   end

   assign in_ready  = r_inReady;
   assign out_valid = r_outValid;
   assign out       = r_out;
   assign invalid   = r_invalid;
   assign inexact   = r_inexact;

endmodule
